// File: rtl/counter_mod_updown_pkg.sv
// Shared types and helpers for the modulus up/down counter.
package counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum logic {BOUND_WRAP = 1'b0, BOUND_SAT = 1'b1} bound_e;

  localparam int unsigned CNT_MAX_WIDTH = 32;

  // Limits a load value to the terminal count; wide enough for any legal WIDTH.
  function automatic logic [CNT_MAX_WIDTH:0] clamp_load(
    input logic [CNT_MAX_WIDTH:0] data,
    input logic [CNT_MAX_WIDTH:0] limit
  );
    if (data > limit) begin
      return limit;
    end else begin
      return data;
    end
  endfunction

endpackage

// File: rtl/counter_mod_updown_next.sv
// Combinational next-count and boundary detection for counter_mod_updown.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [CNT_MAX_WIDTH:0] MAX_VAL = (33'd1 << WIDTH) - 33'd1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] next_count,
  output logic             boundary_hit
);

  // One extra bit so MAX_VAL = 2**WIDTH-1 never aliases during the step.
  localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX_VAL);

  dir_e           dir_s;
  bound_e         bound_s;
  logic [WIDTH:0] count_ext_s;
  logic [WIDTH:0] next_ext_s;

  assign dir_s       = dir_e'(up_dn);
  assign bound_s     = bound_e'(sat);
  assign count_ext_s = {1'b0, count};

  // Next value: clamped load, or one step with wrap/saturate at the limits.
  always_comb begin
    next_ext_s   = count_ext_s;
    boundary_hit = 1'b0;
    if (load) begin
      next_ext_s = (WIDTH+1)'(clamp_load((CNT_MAX_WIDTH+1)'(load_data), MAX_VAL));
    end else begin
      case (dir_s)
        DIR_UP: begin
          if (count_ext_s >= MAX_W) begin
            boundary_hit = 1'b1;
            next_ext_s   = (bound_s == BOUND_SAT) ? MAX_W : '0;
          end else begin
            next_ext_s = count_ext_s + (WIDTH+1)'(1'b1);
          end
        end
        DIR_DOWN: begin
          if (count_ext_s == '0) begin
            boundary_hit = 1'b1;
            next_ext_s   = (bound_s == BOUND_SAT) ? '0 : MAX_W;
          end else begin
            next_ext_s = count_ext_s - (WIDTH+1)'(1'b1);
          end
        end
        default: begin
          next_ext_s = count_ext_s;
        end
      endcase
    end
  end

  assign next_count = WIDTH'(next_ext_s);

endmodule

// File: rtl/counter_mod_updown.sv
// N-bit up/down counter with programmable modulus, parallel load,
// wrap/saturate mode, registered boundary pulse and sticky overflow.
module counter_mod_updown
  import counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [CNT_MAX_WIDTH:0] MAX_VAL   = (33'd1 << WIDTH) - 33'd1,
  parameter logic [CNT_MAX_WIDTH:0] RESET_VAL = 33'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_CNT   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_r;
  logic             evt_r;
  logic             ovf_r;
  logic [WIDTH-1:0] next_count_s;
  logic             boundary_hit_s;
  logic             event_s;

  counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .count        (count_r),
    .up_dn        (up_dn),
    .sat          (sat),
    .load         (load),
    .load_data    (load_data),
    .next_count   (next_count_s),
    .boundary_hit (boundary_hit_s)
  );

  // A load masks any boundary the step logic would otherwise report.
  assign event_s = en & ~load & boundary_hit_s;

  // Count, event pulse and sticky overflow with reset > load > enable priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= RESET_CNT;
      evt_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (load || en) begin
        count_r <= next_count_s;
      end else begin
        count_r <= count_r;
      end
      evt_r <= event_s;
      if (event_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  assign count = count_r;
  assign evt   = evt_r;
  assign ovf   = ovf_r;
  assign tc    = en & ((up_dn & (count_r == MAX_CNT)) | (~up_dn & (count_r == '0)));

endmodule

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
- Parametrised successor to the team's 4-bit loadable counter: N-bit up/down counter with programmable modulus, count enable, parallel load, and wrap or saturate mode.
- Emits a registered wrap/saturate event pulse and a sticky overflow flag.
- Used as a cycle/event counter and divider in datapath and control blocks.
- One clock domain; no handshake beyond the enable and load strobes.

Parameters:
- WIDTH, 8, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, terminal value; count range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- RESET_VAL, 0, value of count after reset; must be <= MAX_VAL.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable; one step per cycle when high
- up_dn  input  1  direction: 1 = increment, 0 = decrement
- sat  input  1  boundary mode: 1 = saturate at limit, 0 = wrap modulo MAX_VAL+1
- load  input  1  parallel load strobe
- load_data  input  WIDTH  value to load
- clr_ovf  input  1  clears sticky overflow flag
- count  output  WIDTH  current count (registered)
- tc  output  1  terminal count (combinational): en & ((up_dn & count==MAX_VAL) | (!up_dn & count==0))
- evt  output  1  registered one-cycle pulse: a boundary was hit on the previous edge (wrapped or blocked by saturation)
- ovf  output  1  sticky flag, set on any boundary event

Behaviour:
- One clock; reset is synchronous and active-high. All state updates occur on the rising edge of clk. reset is sampled only at that edge and has no asynchronous effect.
- Reset values: count = RESET_VAL, evt = 0, ovf = 0. reset overrides all other inputs in the same cycle, including an operation in progress.
- Priority per cycle: reset > load > en.
- Load:
  - load=1 sets count = min(load_data, MAX_VAL) in one cycle, regardless of en.
  - Clamping applies when load_data > MAX_VAL.
  - A load never produces evt.
- Count, en=1, load=0:
  - Up, count < MAX_VAL: count+1.
  - Down, count > 0: count-1.
  - Up at MAX_VAL, sat=0: next count = 0, evt=1 next cycle.
  - Up at MAX_VAL, sat=1: count holds MAX_VAL, evt=1 next cycle.
  - Down at 0, sat=0: next count = MAX_VAL, evt=1.
  - Down at 0, sat=1: count holds 0, evt=1.
- Hold: en=0 and load=0 leaves count unchanged. evt=0.
- evt is registered and asserted for exactly one cycle per boundary event. It is re-asserted every cycle the counter sits at the limit with en=1 and sat=1.
- ovf:
  - Set on the edge where evt is set.
  - Cleared by clr_ovf=1.
  - If clr_ovf and a boundary event occur in the same cycle, set wins (ovf=1).
- Arithmetic:
  - Next-value computation uses WIDTH+1 bits internally so MAX_VAL = 2**WIDTH-1 cannot alias.
  - The limit compare is against MAX_VAL, not against bit overflow.
- up_dn and sat may change every cycle. Each edge uses the values present at that edge.
- tc is purely combinational from registered count plus en/up_dn. It is glitch-tolerant only; consumers sample it at the clock.

Decomposition:
- Package counter_pkg:
  - typedef dir_e {DIR_DOWN=0, DIR_UP=1}
  - typedef bound_e {BOUND_WRAP=0, BOUND_SAT=1}
  - localparam function clamp helper for load value
- Sub-module counter_next (combinational):
  - Inputs: count, up_dn, sat, load, load_data.
  - Outputs: next_count, boundary_hit.
  - Top module holds the registers (count, evt, ovf) and reset/priority logic.

Test Plan:
- WIDTH=4, MAX_VAL=9. Reset, then en=1, up_dn=1, sat=0 for 12 cycles -> count 0,1,..,9,0,1. evt high exactly one cycle after the 9->0 edge. ovf=1 thereafter.
- Same config, sat=1, count up from 7 for 5 cycles -> 8,9,9,9,9. evt high on each cycle after a blocked step. tc=1 while count=9.
- Down from 2, sat=0 -> 1,0,9,8. evt after the 0->9 edge. Then sat=1 at count=0 -> holds 0 with evt pulses.
- load=1, load_data=4'd14 with en=1 -> count=9 (clamped), evt=0. Next cycle, load=1 and en=1 with load_data=3 -> count=3 (load wins).
- Boundary event and clr_ovf=1 in the same cycle -> ovf stays 1. Next cycle clr_ovf=1 with no event -> ovf=0.
- Mid-count at 6, assert reset with load=1 and en=1 -> count=RESET_VAL (0), evt=0, ovf=0 on that edge. Counting resumes from 0 after reset drops.
